// File: rtl/tmr_pkg.sv
// -----------------------------------------------------------------------------
// tmr_pkg
// Shared definitions for the triple-modular-redundancy fault manager:
//   - state_t      : fault manager FSM states
//   - ID_*         : copy-index encodings (A=0, B=1, C=2, NONE=3)
//   - DEF_*        : default timing parameters
//   - id_to_mask   : copy index -> one-hot copy mask (NONE -> zero)
//   - mask_to_id   : one-hot copy mask -> copy index (anything else -> NONE)
// No ports; imported by the fault manager and its counter.
// -----------------------------------------------------------------------------
package tmr_pkg;

   typedef enum logic [2:0] {
      ST_MONITOR   = 3'd0,
      ST_CONFIRM   = 3'd1,
      ST_WAIT_IDLE = 3'd2,
      ST_RESYNC    = 3'd3,
      ST_FATAL     = 3'd4
   } state_t;

   localparam logic [1:0] ID_A    = 2'd0;
   localparam logic [1:0] ID_B    = 2'd1;
   localparam logic [1:0] ID_C    = 2'd2;
   localparam logic [1:0] ID_NONE = 2'd3;

   localparam int DEF_CONFIRM_N    = 4;
   localparam int DEF_RST_LEN      = 8;
   localparam int DEF_IDLE_TIMEOUT = 255;

   function automatic logic [2:0] id_to_mask(input logic [1:0] id);
      logic [2:0] mask;
      case (id)
         ID_A:    mask = 3'b001;
         ID_B:    mask = 3'b010;
         ID_C:    mask = 3'b100;
         default: mask = 3'b000;
      endcase
      return mask;
   endfunction

   function automatic logic [1:0] mask_to_id(input logic [2:0] mask);
      logic [1:0] id;
      case (mask)
         3'b001:  id = ID_A;
         3'b010:  id = ID_B;
         3'b100:  id = ID_C;
         default: id = ID_NONE;
      endcase
      return id;
   endfunction

endpackage

// File: rtl/tmr_cycle_counter.sv
// -----------------------------------------------------------------------------
// tmr_cycle_counter
// 8-bit cycle counter with synchronous clear, enable and terminal-count compare.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset (count -> 0)
//   clr   in   synchronous clear; clr together with en restarts the count at 1
//   en    in   count enable (saturates at 255)
//   term  in   terminal value [7:0]
//   done  out  high while count equals term
// -----------------------------------------------------------------------------
module tmr_cycle_counter
   import tmr_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] term,
   output logic       done
);

   logic [7:0] count;

   // Clear with enable loads 1 so that a restart can count the current cycle
   // as the first one without an extra load port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 8'd0;
      end else if (clr) begin
         count <= en ? 8'd1 : 8'd0;
      end else if (en && (count != 8'hFF)) begin
         count <= count + 8'd1;
      end
   end

   assign done = (count == term);

endmodule

// File: rtl/tmr_fault_manager.sv
// -----------------------------------------------------------------------------
// tmr_fault_manager
// Watches per-copy mismatch flags of a triplicated block, confirms a persistent
// single-copy fault, waits for a safe idle point and pulses a reset to the
// faulty copy. Multi-copy disagreement or a stuck resync escalates to a sticky
// fatal error. CONFIRM_N, RST_LEN and IDLE_TIMEOUT are expected to be >= 2.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   mis[2:0]   in   per-copy mismatch vs. voted outputs (bit0=A, bit1=B, bit2=C)
//   idle       in   safe resync point
//   clr_err    in   clears the fatal error (only honoured in FATAL)
//   copy_rst   out  registered per-copy reset request, one-hot or zero
//   fault_id   out  last confirmed faulty copy (3 = none)
//   tmr_error  out  sticky unrecoverable error
//   err_cnt    out  completed resyncs, saturating at 255
//   busy       out  high in every state other than MONITOR
// -----------------------------------------------------------------------------
module tmr_fault_manager
   import tmr_pkg::*;
#(
   parameter int CONFIRM_N    = DEF_CONFIRM_N,
   parameter int RST_LEN      = DEF_RST_LEN,
   parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] mis,
   input  logic       idle,
   input  logic       clr_err,
   output logic [2:0] copy_rst,
   output logic [1:0] fault_id,
   output logic       tmr_error,
   output logic [7:0] err_cnt,
   output logic       busy
);

   // The shared counter holds (cycles spent in the current phase - 1), so each
   // phase terminates when the count reaches its length minus one.
   localparam logic [7:0] CONFIRM_TERM = 8'(CONFIRM_N - 1);
   localparam logic [7:0] WAIT_TERM    = 8'(IDLE_TIMEOUT - 1);
   localparam logic [7:0] RST_TERM     = 8'(RST_LEN - 1);

   state_t     state;
   state_t     next_state;
   logic [1:0] candidate;
   logic       cnt_clr;
   logic       cnt_en;
   logic [7:0] cnt_term;
   logic       cnt_done;
   logic       mis_multi;
   logic       mis_single;
   logic       mis_other;

   assign mis_multi  = (mis[0] & mis[1]) | (mis[0] & mis[2]) | (mis[1] & mis[2]);
   assign mis_single = (mis != 3'b000) && !mis_multi;
   assign mis_other  = |(mis & ~id_to_mask(fault_id));

   tmr_cycle_counter u_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .term (cnt_term),
      .done (cnt_done)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_MONITOR;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and counter control. Any state change clears the counter so
   // each phase starts counting from zero; entering or restarting CONFIRM
   // loads 1 because the triggering cycle already counts as a mismatch.
   always_comb begin
      next_state = state;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      cnt_term   = 8'd0;
      unique case (state)
         ST_MONITOR: begin
            cnt_clr = 1'b1;
            if (mis_multi) begin
               next_state = ST_FATAL;
            end else if (mis_single) begin
               next_state = ST_CONFIRM;
               cnt_en     = 1'b1;
            end
         end
         ST_CONFIRM: begin
            cnt_term = CONFIRM_TERM;
            if (mis_multi) begin
               next_state = ST_FATAL;
               cnt_clr    = 1'b1;
            end else if (mis == 3'b000) begin
               next_state = ST_MONITOR;
               cnt_clr    = 1'b1;
            end else if (mis == id_to_mask(candidate)) begin
               if (cnt_done) begin
                  next_state = ST_WAIT_IDLE;
                  cnt_clr    = 1'b1;
               end else begin
                  cnt_en = 1'b1;
               end
            end else begin
               cnt_clr = 1'b1;
               cnt_en  = 1'b1;
            end
         end
         ST_WAIT_IDLE: begin
            cnt_term = WAIT_TERM;
            if (mis_other || (!idle && cnt_done)) begin
               next_state = ST_FATAL;
               cnt_clr    = 1'b1;
            end else if (idle) begin
               next_state = ST_RESYNC;
               cnt_clr    = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_RESYNC: begin
            cnt_term = RST_TERM;
            if (mis_other) begin
               next_state = ST_FATAL;
               cnt_clr    = 1'b1;
            end else if (cnt_done) begin
               next_state = ST_MONITOR;
               cnt_clr    = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_FATAL: begin
            cnt_clr = 1'b1;
            if (clr_err) begin
               next_state = ST_MONITOR;
            end
         end
         default: begin
            next_state = ST_MONITOR;
            cnt_clr    = 1'b1;
         end
      endcase
   end

   // Decoded status outputs.
   always_comb begin
      busy      = (state != ST_MONITOR);
      tmr_error = (state == ST_FATAL);
   end

   // Candidate tracking, confirmed fault id, resync counter and the registered
   // copy reset. copy_rst follows next_state so it rises with RESYNC entry and
   // drops on the same edge that leaves RESYNC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         candidate <= ID_NONE;
         fault_id  <= ID_NONE;
         err_cnt   <= 8'd0;
         copy_rst  <= 3'b000;
      end else begin
         if (((state == ST_MONITOR) || (state == ST_CONFIRM)) && mis_single) begin
            candidate <= mask_to_id(mis);
         end
         if ((state == ST_CONFIRM) && (next_state == ST_WAIT_IDLE)) begin
            fault_id <= candidate;
         end
         if ((state == ST_RESYNC) && (next_state == ST_MONITOR) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
         end
         copy_rst <= (next_state == ST_RESYNC) ? id_to_mask(fault_id) : 3'b000;
      end
   end

endmodule
